if_layer_tm: RTL and testbench

Parametrised, time-multiplexed integrate-and-fire layer. It is the successor to the single fixed IF network instance. It holds NUM_OUTPUTS neurons, each fully connected to NUM_INPUTS spike inputs through a runtime-writable signed weight array. A shared update datapath processes one neuron per clock, so a timestep costs NUM_OUTPUTS+1 cycles. It sits between a spike encoder (upstream) and a next layer or readout (downstream), using a valid/ready step handshake.

---
 rtl/if_layer_tm.sv | 195 +++++++++++++++++++
 tb/tb_if_layer_tm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_layer_tm.sv
// Time-multiplexed integrate-and-fire layer.
// NUM_OUTPUTS neurons share one update datapath. Each neuron is fully
// connected to NUM_INPUTS spike lines through a runtime-writable signed
// weight array. One neuron is updated per clock. A timestep is started with
// a valid/ready handshake and ends with a one-cycle spike_valid pulse.
module if_layer_tm #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 4,
  parameter int WEIGHT_SIZE = 8,
  parameter int POT_SIZE    = 16,
  parameter int THRESH      = 4,
  parameter int RESET       = 0,
  parameter int REFRAC      = 0,
  parameter int LEAK        = 0,
  localparam int ADDR_W     = ((NUM_INPUTS * NUM_OUTPUTS) > 1) ?
                              $clog2(NUM_INPUTS * NUM_OUTPUTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step_valid,
  output logic                   step_ready,
  input  logic [NUM_INPUTS-1:0]  spike_in,
  output logic [NUM_OUTPUTS-1:0] spike_out,
  output logic                   spike_valid,
  input  logic                   w_en,
  input  logic [ADDR_W-1:0]      w_addr,
  input  logic [WEIGHT_SIZE-1:0] w_data
);

  localparam int IDX_W      = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam int REF_W      = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  // Wide enough for the potential plus every weight at once and the leak,
  // so the raw sum can never wrap before saturation.
  localparam int SUM_BASE_W = (POT_SIZE > WEIGHT_SIZE) ? POT_SIZE : WEIGHT_SIZE;
  localparam int ACC_W      = SUM_BASE_W + $clog2(NUM_INPUTS) + 2;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUTPUTS - 1);

  localparam logic signed [ACC_W-1:0] POT_MAX_ACC =
    {{(ACC_W - POT_SIZE + 1){1'b0}}, {(POT_SIZE - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] POT_MIN_ACC =
    {{(ACC_W - POT_SIZE + 1){1'b1}}, {(POT_SIZE - 1){1'b0}}};
  localparam logic signed [ACC_W-1:0]    LEAK_ACC   = ACC_W'(LEAK);
  localparam logic signed [POT_SIZE-1:0] THRESH_POT = POT_SIZE'(THRESH);
  localparam logic signed [POT_SIZE-1:0] RESET_POT  = POT_SIZE'(RESET);
  localparam logic [REF_W-1:0]           REFRAC_CNT = REF_W'(REFRAC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [NUM_INPUTS-1:0]   in_lat;
  logic [NUM_OUTPUTS-1:0]  scratch;

  logic signed [WEIGHT_SIZE-1:0] weights [NUM_OUTPUTS][NUM_INPUTS];
  logic signed [POT_SIZE-1:0]    pot     [NUM_OUTPUTS];
  logic [REF_W-1:0]              refrac  [NUM_OUTPUTS];

  logic signed [POT_SIZE-1:0] pot_cur;
  logic [REF_W-1:0]           ref_cur;
  logic signed [ACC_W-1:0]    acc;
  logic signed [POT_SIZE-1:0] sat_sum;
  logic signed [POT_SIZE-1:0] pot_nxt;
  logic [REF_W-1:0]           ref_nxt;
  logic                       fire;
  logic [NUM_OUTPUTS-1:0]     spikes_nxt;

  function automatic logic signed [ACC_W-1:0] ext_pot(
    input logic signed [POT_SIZE-1:0] v);
    return {{(ACC_W - POT_SIZE){v[POT_SIZE-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] ext_w(
    input logic signed [WEIGHT_SIZE-1:0] v);
    return {{(ACC_W - WEIGHT_SIZE){v[WEIGHT_SIZE-1]}}, v};
  endfunction

  // Clamp the wide sum to the signed potential range.
  function automatic logic signed [POT_SIZE-1:0] sat_pot(
    input logic signed [ACC_W-1:0] v);
    logic signed [POT_SIZE-1:0] r;
    if (v > POT_MAX_ACC)
      r = POT_MAX_ACC[POT_SIZE-1:0];
    else if (v < POT_MIN_ACC)
      r = POT_MIN_ACC[POT_SIZE-1:0];
    else
      r = v[POT_SIZE-1:0];
    return r;
  endfunction

  // Shared neuron update for the neuron selected by idx.
  always_comb begin
    pot_cur = pot[idx];
    ref_cur = refrac[idx];
    acc     = ext_pot(pot_cur);
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (in_lat[i])
        acc = acc + ext_w(weights[idx][i]);
    end
    acc     = acc - LEAK_ACC;
    sat_sum = sat_pot(acc);

    fire    = 1'b0;
    pot_nxt = sat_sum;
    ref_nxt = ref_cur;
    if (ref_cur != '0) begin
      // Refractory neurons ignore inputs and leak and sit at the reset level.
      ref_nxt = ref_cur - REF_W'(1);
      pot_nxt = RESET_POT;
    end else if (sat_sum >= THRESH_POT) begin
      fire    = 1'b1;
      pot_nxt = RESET_POT;
      ref_nxt = REFRAC_CNT;
    end

    spikes_nxt      = scratch;
    spikes_nxt[idx] = fire;
  end

  // Step sequencing, handshake and registered spike outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      in_lat      <= '0;
      scratch     <= '0;
      spike_out   <= '0;
      spike_valid <= 1'b0;
      step_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          spike_valid <= 1'b0;
          if (step_valid && step_ready) begin
            in_lat     <= spike_in;
            idx        <= '0;
            scratch    <= '0;
            step_ready <= 1'b0;
            state      <= UPDATE;
          end
        end
        UPDATE: begin
          scratch <= spikes_nxt;
          if (idx == IDX_LAST) begin
            // Publish on the last update so the result is visible in DONE.
            spike_out   <= spikes_nxt;
            spike_valid <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          spike_valid <= 1'b0;
          step_ready  <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          spike_valid <= 1'b0;
          step_ready  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Neuron state and weight storage; a write lands after the current update reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        pot[o]    <= RESET_POT;
        refrac[o] <= '0;
        for (int i = 0; i < NUM_INPUTS; i++)
          weights[o][i] <= '0;
      end
    end else begin
      // Addresses beyond the array match no entry and are dropped.
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (w_en && (w_addr == ADDR_W'(o * NUM_INPUTS + i)))
            weights[o][i] <= w_data;
        end
      end
      if (state == UPDATE) begin
        pot[idx]    <= pot_nxt;
        refrac[idx] <= ref_nxt;
      end
    end
  end

endmodule

// File: tb/tb_if_layer_tm.sv
// Directed bench for if_layer_tm: four instances (default, refractory,
// narrow potential, leaky) share the stimulus; each vector selects which
// instance's outputs it judges.
module tb_if_layer_tm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       step_valid = 1'b0;
  logic [3:0] spike_in = '0;
  logic       w_en = 1'b0;
  logic [3:0] w_addr = '0;
  logic [7:0] w_data = '0;

  logic [3:0] so [4];
  logic       sv [4];
  logic       sr [4];

  int errors = 0;
  int checks = 0;

  localparam int DEF = 0, REF = 1, SAT = 2, LK = 3;

  always #5 clk = ~clk;

  if_layer_tm u_def (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(sr[0]),
    .spike_in(spike_in), .spike_out(so[0]), .spike_valid(sv[0]),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data));

  if_layer_tm #(.REFRAC(2)) u_ref (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(sr[1]),
    .spike_in(spike_in), .spike_out(so[1]), .spike_valid(sv[1]),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data));

  if_layer_tm #(.POT_SIZE(8)) u_sat (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(sr[2]),
    .spike_in(spike_in), .spike_out(so[2]), .spike_valid(sv[2]),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data));

  if_layer_tm #(.LEAK(1)) u_leak (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(sr[3]),
    .spike_in(spike_in), .spike_out(so[3]), .spike_valid(sv[3]),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data));

  typedef struct {
    int         sel;
    bit         do_rst;
    bit         wr;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic [3:0] sin;
    logic [3:0] exp_out;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step_valid = 1'b0;
    w_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input logic [3:0] a, input logic [7:0] d);
    w_en = 1'b1;
    w_addr = a;
    w_data = d;
    @(posedge clk);
    #1;
    w_en = 1'b0;
  endtask

  // Handshake, then count edges until spike_valid; leaves the DUT idle.
  task automatic run_step(input int sel, input logic [3:0] sin,
                          output logic [3:0] out, output int lat);
    spike_in = sin;
    step_valid = 1'b1;
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (sv[sel]) break;
    end
    out = so[sel];
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit hit, required $finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] out;
    int lat;
    int lowc;
    int vc;

    //              sel  rst wr addr   data    sin      exp
    vecs[0]  = '{DEF, 0, 0, 4'd0, 8'h00, 4'b1111, 4'b0000};
    vecs[1]  = '{DEF, 0, 1, 4'd0, 8'h02, 4'b0001, 4'b0000};
    vecs[2]  = '{DEF, 0, 0, 4'd0, 8'h00, 4'b0001, 4'b0001};
    vecs[3]  = '{DEF, 0, 0, 4'd0, 8'h00, 4'b0001, 4'b0000};
    vecs[4]  = '{REF, 1, 1, 4'd4, 8'h05, 4'b0001, 4'b0010};
    vecs[5]  = '{REF, 0, 0, 4'd0, 8'h00, 4'b0001, 4'b0000};
    vecs[6]  = '{REF, 0, 0, 4'd0, 8'h00, 4'b0001, 4'b0000};
    vecs[7]  = '{REF, 0, 0, 4'd0, 8'h00, 4'b0001, 4'b0010};
    vecs[8]  = '{SAT, 1, 1, 4'd0, 8'h80, 4'b0001, 4'b0000};
    vecs[9]  = '{SAT, 0, 0, 4'd0, 8'h00, 4'b0001, 4'b0000};
    vecs[10] = '{SAT, 0, 0, 4'd0, 8'h00, 4'b0001, 4'b0000};
    vecs[11] = '{SAT, 0, 0, 4'd0, 8'h00, 4'b0001, 4'b0000};
    vecs[12] = '{SAT, 0, 1, 4'd0, 8'h7F, 4'b0001, 4'b0000};
    vecs[13] = '{SAT, 0, 0, 4'd0, 8'h00, 4'b0001, 4'b0001};
    vecs[14] = '{LK,  1, 1, 4'd0, 8'h04, 4'b0001, 4'b0000};
    vecs[15] = '{LK,  0, 0, 4'd0, 8'h00, 4'b0000, 4'b0000};
    vecs[16] = '{LK,  0, 0, 4'd0, 8'h00, 4'b0000, 4'b0000};
    vecs[17] = '{LK,  0, 0, 4'd0, 8'h00, 4'b0000, 4'b0000};
    vecs[18] = '{LK,  0, 0, 4'd0, 8'h00, 4'b0001, 4'b0000};
    vecs[19] = '{LK,  0, 0, 4'd0, 8'h00, 4'b0001, 4'b0001};

    // Reset held with random activity on every input.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      step_valid = 1'($urandom);
      spike_in   = 4'($urandom);
      w_en       = 1'($urandom);
      w_addr     = 4'($urandom);
      w_data     = 8'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("rst_spike_out_%0d", k), so[DEF], 4'b0000);
      check($sformatf("rst_spike_valid_%0d", k), sv[DEF], 1'b0);
    end
    step_valid = 1'b0;
    w_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_step_ready", sr[DEF], 1'b1);

    // Table: spike_valid appears 4 edges after the handshake edge, i.e. in
    // cycle NUM_OUTPUTS+1 counting the handshake cycle as 0.
    for (int k = 0; k < 20; k++) begin
      if (vecs[k].do_rst) do_reset();
      if (vecs[k].wr) write_w(vecs[k].waddr, vecs[k].wdata);
      run_step(vecs[k].sel, vecs[k].sin, out, lat);
      check($sformatf("vec%0d_spike_out", k), out, vecs[k].exp_out);
      check($sformatf("vec%0d_latency", k), lat, 4);
    end

    // Write to neuron 0 in the same cycle it is updated: old weight 4 fires.
    do_reset();
    write_w(4'd0, 8'd4);
    spike_in = 4'b0001;
    step_valid = 1'b1;
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    w_en = 1'b1;
    w_addr = 4'd0;
    w_data = 8'd0;
    @(posedge clk);
    #1;
    w_en = 1'b0;
    lat = 0;
    while (lat < 20 && !sv[DEF]) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("samecyc_valid_seen", sv[DEF], 1'b1);
    check("samecyc_old_weight", so[DEF], 4'b0001);
    @(posedge clk);
    #1;
    run_step(DEF, 4'b0001, out, lat);
    check("samecyc_new_weight", out, 4'b0000);

    // step_valid during UPDATE is ignored; one pulse, ready low 5 cycles.
    do_reset();
    spike_in = 4'b0000;
    step_valid = 1'b1;
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    lowc = 0;
    vc = 0;
    for (int k = 0; k < 10; k++) begin
      if (!sr[DEF]) lowc++;
      if (sv[DEF]) vc++;
      if (k == 1) step_valid = 1'b1;
      if (k == 2) step_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    check("hs_ready_low_cycles", lowc, 5);
    check("hs_valid_pulses", vc, 1);
    check("hs_ready_after", sr[DEF], 1'b1);

    // Asynchronous reset in cycle 2 of a step.
    do_reset();
    write_w(4'd0, 8'd5);
    run_step(DEF, 4'b0001, out, lat);
    check("arst_pre_spike", out, 4'b0001);
    spike_in = 4'b0001;
    step_valid = 1'b1;
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("arst_spike_out", so[DEF], 4'b0000);
    check("arst_spike_valid", sv[DEF], 1'b0);
    check("arst_step_ready", sr[DEF], 1'b1);
    @(negedge clk);
    rst = 1'b1;
    vc = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (sv[DEF]) vc++;
    end
    check("arst_no_valid", vc, 0);
    run_step(DEF, 4'b0001, out, lat);
    check("arst_weights_cleared", out, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
